// File: rtl/debug_read_arbiter.sv
// Debug read arbiter: two requesters share the core's debug read ports.
// Requests are granted round-robin and run one at a time. The core is frozen
// through debug_enable, and the freeze is released after an idle period.
module debug_read_arbiter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned INST_W     = 16,
  parameter int unsigned D_ADDR_W   = 12,
  parameter int unsigned I_ADDR_W   = 12,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned ARM_CYC    = 2,
  parameter int unsigned LINGER_CYC = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  input  logic [3:0]          req_space,
  input  logic [23:0]         req_addr,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [15:0]         rsp_data,
  output logic                debug_enable,
  output logic [3:0]          reg_debug_addr,
  output logic [D_ADDR_W-1:0] dmem_debug_addr,
  output logic [I_ADDR_W-1:0] imem_debug_addr,
  input  logic [DATA_W-1:0]   reg_debug_rdata,
  input  logic [DATA_W-1:0]   dmem_debug_rdata,
  input  logic [INST_W-1:0]   imem_debug_rdata
);

  localparam int unsigned RSP_W  = 16;
  localparam int unsigned ARM_W  = $clog2(ARM_CYC) + 1;
  localparam int unsigned WAIT_W = $clog2(RD_LAT) + 1;
  localparam int unsigned IDLE_W = $clog2(LINGER_CYC) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_READY,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ARM_W-1:0]    arm_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [IDLE_W-1:0]   idle_cnt_q;
  logic                last_grant_q;
  logic                cap_idx_q;
  logic [1:0]          cap_space_q;
  logic                grant_c;
  logic                fire_c;
  logic [1:0]          sel_space_c;
  logic [11:0]         sel_addr_c;

  // Round-robin pick and the request fields of the chosen requester
  always_comb begin
    grant_c = 1'b0;
    if (req_valid == 2'b11) begin
      grant_c = ~last_grant_q;
    end else begin
      grant_c = req_valid[1];
    end
    sel_space_c = grant_c ? req_space[3:2] : req_space[1:0];
    sel_addr_c  = grant_c ? req_addr[23:12] : req_addr[11:0];
  end

  // Next-state decode; handshake is only open in READY
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    fire_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) state_d = S_ARM;
      end
      S_ARM: begin
        if (arm_cnt_q == ARM_W'(ARM_CYC - 1)) state_d = S_READY;
      end
      S_READY: begin
        req_ready = req_valid & (grant_c ? 2'b10 : 2'b01);
        fire_c    = |req_valid;
        if (fire_c) begin
          state_d = S_WAIT;
        end else if (idle_cnt_q == IDLE_W'(LINGER_CYC - 1)) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_W'(RD_LAT - 1)) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_READY;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, captured request and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      arm_cnt_q       <= '0;
      wait_cnt_q      <= '0;
      idle_cnt_q      <= '0;
      last_grant_q    <= 1'b1;
      cap_idx_q       <= 1'b0;
      cap_space_q     <= 2'b00;
      debug_enable    <= 1'b0;
      rsp_valid       <= 2'b00;
      rsp_data        <= '0;
      reg_debug_addr  <= '0;
      dmem_debug_addr <= '0;
      imem_debug_addr <= '0;
    end else begin
      state_q      <= state_d;
      debug_enable <= (state_d != S_IDLE);
      arm_cnt_q    <= (state_q == S_ARM) ? arm_cnt_q + ARM_W'(1) : '0;
      wait_cnt_q   <= (state_q == S_WAIT) ? wait_cnt_q + WAIT_W'(1) : '0;
      idle_cnt_q   <= (state_q == S_READY && !fire_c) ? idle_cnt_q + IDLE_W'(1) : '0;

      if (fire_c) begin
        last_grant_q    <= grant_c;
        cap_idx_q       <= grant_c;
        cap_space_q     <= sel_space_c;
        reg_debug_addr  <= sel_addr_c[3:0];
        dmem_debug_addr <= sel_addr_c[D_ADDR_W-1:0];
        imem_debug_addr <= sel_addr_c[I_ADDR_W-1:0];
      end

      if (state_q == S_WAIT && state_d == S_RESP) begin
        case (cap_space_q)
          2'b10:   rsp_data <= RSP_W'(imem_debug_rdata);
          2'b11:   rsp_data <= RSP_W'(dmem_debug_rdata);
          default: rsp_data <= RSP_W'(reg_debug_rdata);
        endcase
      end

      rsp_valid <= (state_d == S_RESP) ? (cap_idx_q ? 2'b10 : 2'b01) : 2'b00;
    end
  end

endmodule

// File: tb/tb_debug_read_arbiter.sv
// Directed bench for debug_read_arbiter: one instance with RD_LAT=1 and one
// with RD_LAT=3 sharing the request payload and read-data buses.
module tb_debug_read_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_valid_b;
  logic [3:0]  req_space;
  logic [23:0] req_addr;
  logic [7:0]  reg_rdata;
  logic [7:0]  dmem_rdata;
  logic [15:0] imem_rdata;

  logic [1:0]  req_ready,  req_ready_b;
  logic [1:0]  rsp_valid,  rsp_valid_b;
  logic [15:0] rsp_data,   rsp_data_b;
  logic        de,         de_b;
  logic [3:0]  reg_addr,   reg_addr_b;
  logic [11:0] dmem_addr,  dmem_addr_b;
  logic [11:0] imem_addr,  imem_addr_b;

  int n_cmp = 0;
  int n_err = 0;

  debug_read_arbiter #(.RD_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_space(req_space),
    .req_addr(req_addr), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .debug_enable(de), .reg_debug_addr(reg_addr),
    .dmem_debug_addr(dmem_addr), .imem_debug_addr(imem_addr),
    .reg_debug_rdata(reg_rdata), .dmem_debug_rdata(dmem_rdata),
    .imem_debug_rdata(imem_rdata)
  );

  debug_read_arbiter #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_space(req_space),
    .req_addr(req_addr), .req_ready(req_ready_b), .rsp_valid(rsp_valid_b),
    .rsp_data(rsp_data_b), .debug_enable(de_b), .reg_debug_addr(reg_addr_b),
    .dmem_debug_addr(dmem_addr_b), .imem_debug_addr(imem_addr_b),
    .reg_debug_rdata(reg_rdata), .dmem_debug_rdata(dmem_rdata),
    .imem_debug_rdata(imem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_de"},   32'(de),        32'h0);
    chk({tag, "_rdy"},  32'(req_ready), 32'h0);
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rspd"}, 32'(rsp_data),  32'h0);
    chk({tag, "_rega"}, 32'(reg_addr),  32'h0);
    chk({tag, "_dmma"}, 32'(dmem_addr), 32'h0);
    chk({tag, "_imma"}, 32'(imem_addr), 32'h0);
  endtask

  initial begin
    req_valid   = 2'b00;
    req_valid_b = 2'b00;
    req_space   = 4'b0000;
    req_addr    = 24'h0;
    reg_rdata   = 8'h00;
    dmem_rdata  = 8'h00;
    imem_rdata  = 16'h0000;
    reset       = 1'b1;
    #3;
    chk_all_zero("reset");
    cyc();
    reset = 1'b0;
    cyc();
    chk("idle_de", 32'(de), 32'h0);

    // single dmem read from IDLE
    req_valid  = 2'b01;
    req_space  = 4'b0011;
    req_addr   = {12'h000, 12'h005};
    dmem_rdata = 8'hA5;
    cyc();
    chk("arm1_de", 32'(de), 32'h1);
    chk("arm1_rdy", 32'(req_ready), 32'h0);
    cyc();
    chk("arm2_rdy", 32'(req_ready), 32'h0);
    cyc();
    chk("ready_rdy0", 32'(req_ready), 32'h1);
    cyc();
    chk("wait_dmem_addr", 32'(dmem_addr), 32'h005);
    chk("wait_rdy", 32'(req_ready), 32'h0);
    chk("wait_rspv", 32'(rsp_valid), 32'h0);
    req_valid = 2'b00;
    cyc();
    chk("resp_rspv", 32'(rsp_valid), 32'h1);
    chk("resp_data", 32'(rsp_data), 32'h00A5);
    cyc();
    chk("post_rspv", 32'(rsp_valid), 32'h0);
    chk("post_data_hold", 32'(rsp_data), 32'h00A5);
    chk("post_de", 32'(de), 32'h1);

    // linger with no requests: drop after 16 READY cycles
    repeat (15) cyc();
    chk("linger_last_de", 32'(de), 32'h1);
    cyc();
    chk("linger_drop_de", 32'(de), 32'h0);

    // another dmem read, then a register request in the terminal linger cycle
    req_valid  = 2'b01;
    req_space  = 4'b0011;
    req_addr   = {12'h000, 12'h03C};
    dmem_rdata = 8'h5A;
    repeat (3) cyc();
    chk("rd2_rdy", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 2'b00;
    chk("rd2_wait_rspv", 32'(rsp_valid), 32'h0);
    cyc();
    chk("rd2_rspv", 32'(rsp_valid), 32'h1);
    chk("rd2_data", 32'(rsp_data), 32'h005A);
    cyc();
    repeat (15) cyc();
    chk("term_de", 32'(de), 32'h1);
    chk("term_rdy_idle", 32'(req_ready), 32'h0);
    req_valid = 2'b01;
    req_space = 4'b0001;
    req_addr  = {12'h000, 12'h13A};
    reg_rdata = 8'h7C;
    #1;
    chk("term_rdy", 32'(req_ready), 32'h1);
    cyc();
    chk("term_keep_de", 32'(de), 32'h1);
    chk("reg_addr", 32'(reg_addr), 32'hA);
    req_valid = 2'b00;
    cyc();
    chk("reg_rspv", 32'(rsp_valid), 32'h1);
    chk("reg_data", 32'(rsp_data), 32'h007C);

    // contention from reset: grants alternate 0,1,0,1
    reset      = 1'b1;
    req_valid  = 2'b11;
    req_space  = 4'b1011;
    req_addr   = {12'h022, 12'h011};
    dmem_rdata = 8'h33;
    imem_rdata = 16'h4455;
    #1;
    chk("async_rst_rspv", 32'(rsp_valid), 32'h0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("cont_arm_de", 32'(de), 32'h1);
    cyc();
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("cont_rdy", 32'(req_ready), (k % 2 == 1) ? 32'h2 : 32'h1);
      cyc();
      chk("cont_wait_rdy", 32'(req_ready), 32'h0);
      chk("cont_addr", 32'(dmem_addr), (k % 2 == 1) ? 32'h022 : 32'h011);
      cyc();
      chk("cont_rspv", 32'(rsp_valid), (k % 2 == 1) ? 32'h2 : 32'h1);
      chk("cont_data", 32'(rsp_data), (k % 2 == 1) ? 32'h4455 : 32'h0033);
      chk("cont_resp_rdy", 32'(req_ready), 32'h0);
      cyc();
    end

    // reset asserted in the middle of WAIT
    cyc();
    #2;
    reset     = 1'b1;
    req_valid = 2'b00;
    #1;
    chk_all_zero("midwait");
    cyc();
    reset = 1'b0;
    repeat (6) begin
      cyc();
      chk("abort_rspv", 32'(rsp_valid), 32'h0);
      chk("abort_de", 32'(de), 32'h0);
    end

    // imem read on the RD_LAT=3 instance
    req_valid_b = 2'b10;
    req_space   = 4'b1000;
    req_addr    = {12'hFFF, 12'h000};
    imem_rdata  = 16'hBEEF;
    cyc();
    chk("b_arm_de", 32'(de_b), 32'h1);
    cyc();
    cyc();
    chk("b_rdy", 32'(req_ready_b), 32'h2);
    cyc();
    chk("b_imem_addr", 32'(imem_addr_b), 32'hFFF);
    chk("b_w1_rspv", 32'(rsp_valid_b), 32'h0);
    req_valid_b = 2'b00;
    cyc();
    chk("b_w2_rspv", 32'(rsp_valid_b), 32'h0);
    cyc();
    chk("b_w3_rspv", 32'(rsp_valid_b), 32'h0);
    cyc();
    chk("b_rspv", 32'(rsp_valid_b), 32'h2);
    chk("b_data", 32'(rsp_data_b), 32'hBEEF);
    cyc();
    chk("b_post_rspv", 32'(rsp_valid_b), 32'h0);
    chk("a_untouched_rspv", 32'(rsp_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
